sync_debounce: RTL and testbench
================================

Name: sync_debounce

Overview:
- Multi-channel successor to the basic FF-chain synchronizer.
- Brings WIDTH asynchronous external signals (buttons, switches, slow pins) into the i_clk domain through a parametrised synchronizer chain.
- Per channel, the synchronized value is then debounced by a stability counter, and one-cycle rise/fall pulses are generated.
- Sits between top-level pins and fabric logic, e.g. UART/button/control inputs on the Fomu.

Parameters:
- WIDTH, 1, number of independent channels.
- STAGES, 3, synchronizer FF stages per channel (>= 2).
- DEBOUNCE, 4, consecutive cycles a changed synchronized value must hold before o_level accepts it (0 = no filtering).
- INIT, 0, WIDTH-bit reset value for the synchronizer stages and o_level. Avoids a spurious edge after reset when a pin idles high.

Ports:
- i_clk  input  1  domain clock.
- i_rst  input  1  reset, asynchronous, active-high.
- i_ext  input  WIDTH  external unsynchronized signals.
- o_level  output  WIDTH  debounced, synchronized level.
- o_rise  output  WIDTH  one-cycle pulse when o_level goes 0->1.
- o_fall  output  WIDTH  one-cycle pulse when o_level goes 1->0.
- o_event  output  1  registered OR-reduction of (rise|fall) from the same edge; high in the same cycle as any pulse.

Behaviour:
- Single clock, i_clk. Reset is asynchronous and active-high on i_rst.
- While i_rst is high, immediately and regardless of clock:
  - all stages = INIT, o_level = INIT;
  - counters = 0;
  - o_rise = o_fall = 0, o_event = 0.
- Synchronizer, per channel:
  - Shift register, entering at MSB and exiting at LSB: stage <= {i_ext[n], stage[STAGES-1:1]}.
  - s[n] = stage[0].
  - No logic between stages.
- Counter width: CW = max(1, clog2(DEBOUNCE+1)). The counter never exceeds DEBOUNCE-1, so no wrap-around is possible.
- Debounce FSM, per channel, implicit two states (STABLE: cnt=0; PENDING: cnt>0 or mismatch). Each edge:
  - s == o_level: cnt <= 0 (glitch discarded; no pulse).
  - s != o_level and cnt < DEBOUNCE-1: cnt <= cnt+1.
  - s != o_level and cnt == DEBOUNCE-1: o_level <= s, cnt <= 0, and either o_rise <= s or o_fall <= ~s for that channel.
  - DEBOUNCE = 0: any mismatch updates o_level on the next edge (pure registered compare); counter logic is omitted.
- Pulses:
  - o_rise and o_fall are registered, asserted in the same cycle o_level changes, and cleared on the following edge unless that channel changes again.
  - A channel can change again no earlier than max(DEBOUNCE,1) edges later, so pulses never merge.
- Latency:
  - Edge 1 is the first edge sampling a new steady i_ext value.
  - o_level (and the pulse) updates at edge STAGES + max(DEBOUNCE,1).
  - Defaults: edge 7.
- Channels are fully independent:
  - simultaneous changes on several channels produce simultaneous pulses;
  - o_event is one cycle high.
- Reset mid-count: the count is lost and no pulse is emitted.
  - After release, stages refill from INIT.
  - A channel whose input differs from INIT re-qualifies with the full latency and then pulses once.
- Reset release is synchronous to i_clk externally. This block does not synchronize i_rst deassertion.

Test Plan:
- Reset/idle-high (WIDTH=4, STAGES=3, DEBOUNCE=4, INIT=0): hold i_ext=4'hF, assert i_rst.
  - During reset: o_level=0 with no pulses.
  - After release: o_level=4'hF at edge 7, o_rise=4'hF and o_event=1 for exactly one cycle, then 0.
- Glitch reject: i_ext[0] high for 3 cycles, then low.
  - o_level[0] stays 0; o_rise, o_fall, o_event never assert.
- Chatter: i_ext[1] toggles every 2 cycles for 20 cycles, then held high.
  - Exactly one o_rise[1] pulse, 7 edges after the final transition; o_fall[1] never asserts.
- Fall plus simultaneous channels: from o_level=4'b0100, set i_ext=4'b0010 in one cycle.
  - At edge 7, o_level=4'b0010, o_rise=4'b0010, o_fall=4'b0100 in the same cycle, o_event one cycle.
- Async reset mid-count: i_ext[3] rises; assert i_rst between clock edges at edge 5.
  - Outputs go to INIT before the next edge, with no pulse.
  - After release with i_ext[3] still high: o_rise[3] at edge 7 after release.
- Bypass (DEBOUNCE=0, STAGES=2, INIT=4'hF): drop i_ext to 4'h0.
  - o_level=0 and o_fall=4'hF at edge 3.
  - A 1-cycle pulse on i_ext[2] yields o_rise[2] then o_fall[2] one cycle apart.

Source files
------------

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//
// Brings WIDTH asynchronous external signals (buttons, switches, slow pins)
// into the i_clk domain and turns each one into a clean level with one-cycle
// edge pulses.
//
// Each channel has three parts:
//   1. A plain STAGES-deep flip-flop synchronizer with no logic between
//      stages. i_ext enters at the MSB and the synchronized bit leaves at
//      the LSB.
//   2. A stability counter. A synchronized value that differs from o_level
//      must hold for DEBOUNCE consecutive edges before o_level takes it.
//      DEBOUNCE = 0 removes the counter. o_level then follows the
//      synchronizer output one edge later.
//   3. Registered rise/fall pulses, asserted in the same cycle o_level
//      changes. o_event is their registered OR over all channels.
//
// Parameters:
//   WIDTH    - number of independent channels
//   STAGES   - synchronizer depth per channel (must be >= 2)
//   DEBOUNCE - consecutive edges a changed value must hold (0 = no filter)
//   INIT     - reset value of the synchronizer stages and of o_level
//
// Ports:
//   i_clk   - domain clock
//   i_rst   - asynchronous, active-high reset (release must be synchronous)
//   i_ext   - external, unsynchronized inputs
//   o_level - debounced, synchronized level
//   o_rise  - one-cycle pulse when o_level goes 0->1
//   o_fall  - one-cycle pulse when o_level goes 1->0
//   o_event - high in the same cycle as any rise/fall pulse
// -----------------------------------------------------------------------------

// Invariant checker for the registered outputs. It has no outputs and
// contributes no logic.
module sync_debounce_chk #(
    parameter int WIDTH = 1
) (
    input logic             i_clk,
    input logic             i_rst,
    input logic [WIDTH-1:0] i_level,
    input logic [WIDTH-1:0] i_rise,
    input logic [WIDTH-1:0] i_fall,
    input logic             i_event
);

    // A channel can never rise and fall in the same cycle.
    a_no_double_pulse : assert property (@(posedge i_clk) disable iff (i_rst)
        ((i_rise & i_fall) == {WIDTH{1'b0}}));

    // o_event is exactly the OR of all pulses.
    a_event_matches : assert property (@(posedge i_clk) disable iff (i_rst)
        (i_event == (|(i_rise | i_fall))));

    // A rise pulse leaves its channel high, and a fall pulse leaves it low.
    a_rise_level : assert property (@(posedge i_clk) disable iff (i_rst)
        ((i_rise & ~i_level) == {WIDTH{1'b0}}));
    a_fall_level : assert property (@(posedge i_clk) disable iff (i_rst)
        ((i_fall & i_level) == {WIDTH{1'b0}}));

endmodule

module sync_debounce #(
    parameter int               WIDTH    = 1,
    parameter int               STAGES   = 3,
    parameter int               DEBOUNCE = 4,
    parameter logic [WIDTH-1:0] INIT     = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_ext,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_event
);

    // Counter width. The counter only ever holds 0 .. DEBOUNCE-1.
    localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

    // Synchronizer chains, one STAGES-bit shift register per channel.
    logic [STAGES-1:0] sync_q [WIDTH];
    logic [STAGES-1:0] sync_d [WIDTH];

    // Debounced level and registered pulses.
    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;
    logic             event_q;
    logic             event_d;

    // Synchronized value per channel, and where it disagrees with o_level.
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] diff_s;

    // Channels whose pending value is accepted on this edge.
    logic [WIDTH-1:0] accept_s;

    // Synchronizer shift. The new sample enters at the MSB and the
    // synchronized bit is taken from the LSB.
    always_comb begin
        for (int n = 0; n < WIDTH; n++) begin
            sync_d[n] = {i_ext[n], sync_q[n][STAGES-1:1]};
            sync_s[n] = sync_q[n][0];
        end
        diff_s = sync_s ^ level_q;
    end

    // Synchronizer registers. Reset preloads INIT so that an input idling
    // high does not produce a spurious edge after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < WIDTH; n++) begin
                sync_q[n] <= {STAGES{INIT[n]}};
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    generate
        if (DEBOUNCE > 0) begin : g_filter
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
            localparam logic [CW-1:0] CNT_ONE  = CW'(1);

            logic [CW-1:0] cnt_q [WIDTH];
            logic [CW-1:0] cnt_d [WIDTH];

            // Stability counter. Any edge where the synchronized value
            // agrees with o_level drops a pending change. The edge that
            // reaches the full count accepts the new value and restarts
            // the count from zero.
            always_comb begin
                for (int n = 0; n < WIDTH; n++) begin
                    cnt_d[n]    = {CW{1'b0}};
                    accept_s[n] = 1'b0;
                    if (diff_s[n]) begin
                        if (cnt_q[n] == CNT_LAST) begin
                            accept_s[n] = 1'b1;
                            cnt_d[n]    = {CW{1'b0}};
                        end else begin
                            cnt_d[n]    = cnt_q[n] + CNT_ONE;
                        end
                    end else begin
                        cnt_d[n] = {CW{1'b0}};
                    end
                end
            end

            // Counter registers. Reset discards any partial count.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int n = 0; n < WIDTH; n++) begin
                        cnt_q[n] <= {CW{1'b0}};
                    end
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end else begin : g_bypass
            // With no filtering, every mismatch is accepted on the next edge.
            assign accept_s = diff_s;
        end
    endgenerate

    // Next level and pulses. Accepted channels take the synchronized value.
    // Their pulse direction is simply that new value.
    always_comb begin
        level_d = (level_q & ~accept_s) | (sync_s & accept_s);
        rise_d  = accept_s & sync_s;
        fall_d  = accept_s & ~sync_s;
        event_d = |(rise_d | fall_d);
    end

    // Output registers. Pulses last one cycle because accept_s cannot
    // repeat for a channel on consecutive edges when DEBOUNCE > 1. It can
    // repeat with the opposite polarity when DEBOUNCE <= 1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            level_q <= INIT;
            rise_q  <= {WIDTH{1'b0}};
            fall_q  <= {WIDTH{1'b0}};
            event_q <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_event = event_q;

    sync_debounce_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_level (level_q),
        .i_rise  (rise_q),
        .i_fall  (fall_q),
        .i_event (event_q)
    );

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// Testbench for sync_debounce.
//
// Two instances share the clock and reset:
//   A: WIDTH=4, STAGES=3, DEBOUNCE=4, INIT=4'h0
//   B: WIDTH=4, STAGES=2, DEBOUNCE=0, INIT=4'hF
//
// The reference model keeps a short history of the input samples taken on
// each edge since the last reset release. A channel's level flips on edge t
// when two things hold:
//   - the synchronized input, which is the sample from STAGES edges earlier
//     or INIT before any sample exists, disagreed with the level on each of
//     the last max(DEBOUNCE,1) edges;
//   - the previous flip (or the reset release) is at least that far back.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

    localparam int NCFG = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ext_a = 4'hF;
    logic [3:0] ext_b = 4'hF;

    logic [3:0] lvl_a, rise_a, fall_a;
    logic       evt_a;
    logic [3:0] lvl_b, rise_b, fall_b;
    logic       evt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_debounce #(.WIDTH(4), .STAGES(3), .DEBOUNCE(4), .INIT(4'h0)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_ext(ext_a),
        .o_level(lvl_a), .o_rise(rise_a), .o_fall(fall_a), .o_event(evt_a)
    );

    sync_debounce #(.WIDTH(4), .STAGES(2), .DEBOUNCE(0), .INIT(4'hF)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_ext(ext_b),
        .o_level(lvl_b), .o_rise(rise_b), .o_fall(fall_b), .o_event(evt_b)
    );

    // ---------------- reference model ----------------
    logic [3:0] hist   [NCFG][64];
    int         tcnt   [NCFG];
    int         lastc  [NCFG][4];
    logic [3:0] m_lvl  [NCFG];
    logic [3:0] m_rise [NCFG];
    logic [3:0] m_fall [NCFG];
    logic       m_evt  [NCFG];

    function automatic int st_of(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic int win_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [3:0] init_of(input int k);
        return (k == 0) ? 4'h0 : 4'hF;
    endfunction

    // Synchronized value seen just before edge j of the current episode.
    function automatic logic [3:0] s_at(input int k, input int j);
        if (j - st_of(k) >= 1) return hist[k][(j - st_of(k)) % 64];
        else return init_of(k);
    endfunction

    task automatic model_step(input int k);
        logic [3:0] sv;
        bit         ok;
        int         w;
        w = win_of(k);
        tcnt[k] = tcnt[k] + 1;
        hist[k][tcnt[k] % 64] = (k == 0) ? ext_a : ext_b;
        m_rise[k] = 4'h0;
        m_fall[k] = 4'h0;
        for (int n = 0; n < 4; n++) begin
            ok = (tcnt[k] - w >= lastc[k][n]);
            for (int j = tcnt[k] - w + 1; j <= tcnt[k]; j++) begin
                sv = s_at(k, j);
                if (sv[n] == m_lvl[k][n]) ok = 1'b0;
            end
            if (ok) begin
                m_lvl[k][n] = ~m_lvl[k][n];
                if (m_lvl[k][n]) m_rise[k][n] = 1'b1;
                else m_fall[k][n] = 1'b1;
                lastc[k][n] = tcnt[k];
            end
        end
        m_evt[k] = |(m_rise[k] | m_fall[k]);
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            for (int k = 0; k < NCFG; k++) begin
                if (rst) begin
                    tcnt[k]   = 0;
                    m_lvl[k]  = init_of(k);
                    m_rise[k] = 4'h0;
                    m_fall[k] = 4'h0;
                    m_evt[k]  = 1'b0;
                    for (int n = 0; n < 4; n++) lastc[k][n] = 0;
                end else begin
                    model_step(k);
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check_eq("lvl_a",  32'(lvl_a),  32'(m_lvl[0]));
        check_eq("rise_a", 32'(rise_a), 32'(m_rise[0]));
        check_eq("fall_a", 32'(fall_a), 32'(m_fall[0]));
        check_eq("evt_a",  32'(evt_a),  32'(m_evt[0]));
        check_eq("lvl_b",  32'(lvl_b),  32'(m_lvl[1]));
        check_eq("rise_b", 32'(rise_b), 32'(m_rise[1]));
        check_eq("fall_b", 32'(fall_b), 32'(m_fall[1]));
        check_eq("evt_b",  32'(evt_b),  32'(m_evt[1]));
    endtask

    // Advance to the next falling edge and compare against the model.
    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int npulse;
        int nrise;
        int nfall;
        int rise_at;

        // Reset with every pin idling high.
        #1 rst = 1'b1;
        #1;
        check_eq("rst_lvl_a",  32'(lvl_a),  32'h0);
        check_eq("rst_rise_a", 32'(rise_a), 32'h0);
        check_eq("rst_evt_a",  32'(evt_a),  32'h0);
        check_eq("rst_lvl_b",  32'(lvl_b),  32'hF);
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 6) check_eq("idle_lvl_e6", 32'(lvl_a), 32'h0);
            if (i == 7) begin
                check_eq("idle_lvl_e7",  32'(lvl_a),  32'hF);
                check_eq("idle_rise_e7", 32'(rise_a), 32'hF);
                check_eq("idle_evt_e7",  32'(evt_a),  32'h1);
            end
            if (i == 8) begin
                check_eq("idle_rise_e8", 32'(rise_a), 32'h0);
                check_eq("idle_evt_e8",  32'(evt_a),  32'h0);
            end
        end

        // Drop everything to 0, then send a 3-cycle glitch on channel 0.
        ext_a = 4'h0;
        repeat (12) tick();
        npulse = 0;
        ext_a[0] = 1'b1;
        repeat (3) begin
            tick();
            if ((rise_a | fall_a) != 4'h0 || evt_a) npulse++;
        end
        ext_a[0] = 1'b0;
        repeat (12) begin
            tick();
            if ((rise_a | fall_a) != 4'h0 || evt_a) npulse++;
        end
        check_eq("glitch_pulses", 32'(npulse), 32'h0);
        check_eq("glitch_lvl0",   32'(lvl_a[0]), 32'h0);

        // Chatter on channel 1, toggling every 2 cycles, then a steady high.
        nrise = 0;
        nfall = 0;
        rise_at = 0;
        for (int c = 0; c < 20; c++) begin
            ext_a[1] = (((c / 2) % 2) == 0) ? 1'b1 : 1'b0;
            tick();
            if (rise_a[1]) nrise++;
            if (fall_a[1]) nfall++;
        end
        ext_a[1] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (rise_a[1]) begin
                nrise++;
                rise_at = i;
            end
            if (fall_a[1]) nfall++;
        end
        check_eq("chatter_nrise",   32'(nrise),   32'h1);
        check_eq("chatter_rise_at", 32'(rise_at), 32'h7);
        check_eq("chatter_nfall",   32'(nfall),   32'h0);

        // Fall on one channel and rise on another in the same cycle.
        ext_a = 4'b0100;
        repeat (12) tick();
        check_eq("pre_sim_lvl", 32'(lvl_a), 32'h4);
        ext_a = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) begin
                check_eq("sim_lvl",  32'(lvl_a),  32'h2);
                check_eq("sim_rise", 32'(rise_a), 32'h2);
                check_eq("sim_fall", 32'(fall_a), 32'h4);
                check_eq("sim_evt",  32'(evt_a),  32'h1);
            end
            if (i == 8) check_eq("sim_evt_e8", 32'(evt_a), 32'h0);
        end

        // Asynchronous reset in the middle of a pending count.
        ext_a = 4'h0;
        repeat (12) tick();
        ext_a[3] = 1'b1;
        repeat (4) tick();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_lvl",  32'(lvl_a),  32'h0);
        check_eq("midrst_rise", 32'(rise_a), 32'h0);
        check_eq("midrst_evt",  32'(evt_a),  32'h0);
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 6) check_eq("postrst_rise_e6", 32'(rise_a), 32'h0);
            if (i == 7) check_eq("postrst_rise_e7", 32'(rise_a), 32'h8);
        end

        // Unfiltered instance: drop all pins, then send a 1-cycle pulse on
        // channel 2.
        ext_b = 4'h0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 2) check_eq("byp_lvl_e2", 32'(lvl_b), 32'hF);
            if (i == 3) begin
                check_eq("byp_lvl_e3",  32'(lvl_b),  32'h0);
                check_eq("byp_fall_e3", 32'(fall_b), 32'hF);
                check_eq("byp_evt_e3",  32'(evt_b),  32'h1);
            end
        end
        repeat (3) tick();
        ext_b[2] = 1'b1;
        tick();
        ext_b[2] = 1'b0;
        tick();
        tick();
        check_eq("byp_pulse_rise", 32'(rise_b), 32'h4);
        tick();
        check_eq("byp_pulse_fall", 32'(fall_b), 32'h4);
        check_eq("byp_pulse_rise_off", 32'(rise_b), 32'h0);

        // Random phase with one asynchronous reset part-way through.
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(0, (c < 400) ? 4 : 11) == 0) ext_a[n] = ~ext_a[n];
                if ($urandom_range(0, 2) == 0) ext_b[n] = ~ext_b[n];
            end
            if (c == 400) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1;
                check_eq("rnd_rst_lvl_a", 32'(lvl_a), 32'h0);
                check_eq("rnd_rst_lvl_b", 32'(lvl_b), 32'hF);
                check_eq("rnd_rst_evt",   32'({evt_a, evt_b}), 32'h0);
            end
            if (c == 403) rst = 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
